uart_xfer_ctrl: RTL



---
 rtl/aisys_pkg.sv | 26 ++
 rtl/byte_word_packer.sv | 53 +++++
 rtl/uart_xfer_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/aisys_pkg.sv
// Shared definitions for the UART transfer controller and the system controller
// that drives its uart_en / wrsel handshake.
package aisys_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        RX_DATA,
        TX_FETCH,
        TX_LOAD,
        TX_BYTE,
        DONE,
        REARM
    } uart_xfer_state_t;

    localparam int HDR_LEN = 2;

    localparam logic WRSEL_LOAD   = 1'b1;
    localparam logic WRSEL_UNLOAD = 1'b0;

    function automatic int BYTES_PER_WORD(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte<->word shift register with a byte counter; used for RX
// assembly (bytes enter at the top) and TX serialisation (bytes leave at the bottom).
module byte_word_packer
    import aisys_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] word_in,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_next,
    output logic [7:0]        byte_out,
    output logic              last
);

    localparam int        NB       = BYTES_PER_WORD(DATA_W);
    localparam logic [7:0] LAST_IDX = 8'(NB - 1);

    logic [DATA_W-1:0] sr;
    logic [7:0]        cnt;

    generate
        if (DATA_W == 8) begin : g_single
            assign word_next = byte_in;
        end else begin : g_multi
            assign word_next = {byte_in, sr[DATA_W-1:8]};
        end
    endgenerate

    assign byte_out = sr[7:0];
    assign last     = (cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= word_in;
            cnt <= '0;
        end else if (byte_en) begin
            sr  <= word_next;
            cnt <= last ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/uart_xfer_ctrl.sv
// UART transfer responder: loads a length-prefixed RX frame into the buffer RAM,
// or streams a buffer region out over the TX byte interface.
module uart_xfer_ctrl
    import aisys_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          ADDR_W    = 12,
    parameter int unsigned LOAD_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_en,
    input  logic              wrsel,
    output logic              uart_done,
    input  logic [ADDR_W-1:0] unload_base,
    input  logic [ADDR_W:0]   unload_len,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [31:0] MAX_CNT = 32'(1) << ADDR_W;

    uart_xfer_state_t  state, next_state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic [7:0]        hdr_lo;
    logic [31:0]       hdr_word;
    logic [CNT_W-1:0]  hdr_count;

    logic              rx_take, rx_last;
    logic [DATA_W-1:0] rx_word_next;
    logic [7:0]        rx_byte_unused;
    logic              tx_accept, tx_last;
    logic [DATA_W-1:0] tx_word_unused;

    assign hdr_word  = {16'd0, rx_data, hdr_lo};
    assign hdr_count = CNT_W'((hdr_word > MAX_CNT) ? MAX_CNT : hdr_word);

    assign rx_take   = (state == RX_DATA) && uart_en && rx_valid && (count != '0);
    assign tx_accept = (state == TX_BYTE) && uart_en && tx_valid && tx_ready;

    byte_word_packer #(.DATA_W(DATA_W)) u_rx_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state != RX_DATA),
        .load      (1'b0),
        .word_in   ('0),
        .byte_en   (rx_take),
        .byte_in   (rx_data),
        .word_next (rx_word_next),
        .byte_out  (rx_byte_unused),
        .last      (rx_last)
    );

    byte_word_packer #(.DATA_W(DATA_W)) u_tx_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .load      (state == TX_LOAD),
        .word_in   (mem_rdata),
        .byte_en   (tx_accept),
        .byte_in   (8'd0),
        .word_next (tx_word_unused),
        .byte_out  (tx_data),
        .last      (tx_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A load frame finishes one cycle after its final byte, so the zero check lives in RX_DATA.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (uart_en) begin
                if (wrsel == WRSEL_LOAD)    next_state = HDR0;
                else if (unload_len == '0)  next_state = DONE;
                else                        next_state = TX_FETCH;
            end
            HDR0:     if (!uart_en) next_state = IDLE; else if (rx_valid) next_state = HDR1;
            HDR1:     if (!uart_en) next_state = IDLE; else if (rx_valid) next_state = RX_DATA;
            RX_DATA:  if (!uart_en) next_state = IDLE; else if (count == '0) next_state = DONE;
            TX_FETCH: if (!uart_en) next_state = IDLE; else next_state = TX_LOAD;
            TX_LOAD:  if (!uart_en) next_state = IDLE; else next_state = TX_BYTE;
            TX_BYTE: begin
                if (!uart_en)
                    next_state = IDLE;
                else if (tx_accept && tx_last)
                    next_state = (count == CNT_W'(1)) ? DONE : TX_FETCH;
            end
            DONE:     next_state = REARM;
            REARM:    if (!uart_en) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        uart_done = (state == DONE);
        mem_re    = (state == TX_FETCH);
        mem_addr  = addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            count     <= '0;
            hdr_lo    <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            tx_valid  <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            tx_valid <= (next_state == TX_BYTE);
            if (mem_we) addr <= addr + 1'b1;
            case (state)
                IDLE: if (uart_en) begin
                    addr  <= unload_base;
                    count <= (wrsel == WRSEL_LOAD) ? '0 : unload_len;
                end
                HDR0: if (uart_en && rx_valid) hdr_lo <= rx_data;
                HDR1: if (uart_en && rx_valid) begin
                    count <= hdr_count;
                    addr  <= ADDR_W'(LOAD_BASE);
                end
                RX_DATA: if (rx_take && rx_last && !(mem_we)) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= rx_word_next;
                    count     <= count - CNT_W'(1);
                end else if (rx_take && rx_last) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= rx_word_next;
                    count     <= count - CNT_W'(1);
                end
                TX_BYTE: if (tx_accept && tx_last) begin
                    addr  <= addr + 1'b1;
                    count <= count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
